core_dbg_unit: RTL and testbench

Parametrised debug register unit that sits between the core debug APB slave (request side) and the fetch stage.
- Generalises the flat 32-entry debug register array and single-shot instruction-transfer (ITR) write into three things:
  - a configurable register bank;
  - an ITR FIFO with valid/ready handshake to fetch;
  - a RUN/HALTING/HALTED state machine with status reporting.

---
 rtl/core_dbg_unit_pkg.sv | 37 +++
 rtl/dbg_itr_fifo.sv | 81 ++++++++
 rtl/core_dbg_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_core_dbg_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_dbg_unit_pkg.sv
// ----------------------------------------------------------------------------
// core_dbg_unit_pkg
// Shared definitions for the core debug unit: the run-control state encoding,
// bit positions inside the CTRL command word and the STATUS snapshot, and the
// default debug register indices that replace the old DBGI_* constants.
// No ports; import with core_dbg_unit_pkg::*.
// ----------------------------------------------------------------------------
package core_dbg_unit_pkg;

    // Run-control state. The encoding is visible to software through
    // STATUS[1:0], so the values are pinned explicitly.
    typedef enum logic [1:0] {
        DBG_RUN     = 2'd0,
        DBG_HALTING = 2'd1,
        DBG_HALTED  = 2'd2
    } DbgState;

    // Command bits in a CTRL write. They act as one-shot requests and are
    // never stored.
    localparam int DBG_CTRL_HALT    = 0;
    localparam int DBG_CTRL_RESUME  = 1;
    localparam int DBG_CTRL_CLR_OVF = 2;

    // Field layout of the STATUS read value.
    localparam int DBG_STATUS_STATE_LSB = 0;
    localparam int DBG_STATUS_STATE_W   = 2;
    localparam int DBG_STATUS_EMPTY     = 2;
    localparam int DBG_STATUS_FULL      = 3;
    localparam int DBG_STATUS_OVF       = 4;
    localparam int DBG_STATUS_COUNT_LSB = 8;

    // Default debug register indices.
    localparam int DBG_IDX_CTRL   = 1;
    localparam int DBG_IDX_STATUS = 2;
    localparam int DBG_IDX_ITR    = 3;

endpackage

// File: rtl/dbg_itr_fifo.sv
// ----------------------------------------------------------------------------
// dbg_itr_fifo
// Circular instruction-transfer FIFO between the debug register interface and
// the fetch stage. A push into a full FIFO is still accepted when a pop happens
// in the same cycle, because the slot being written is the one being freed.
// A push that cannot be accepted raises o_drop for that cycle.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (empties the FIFO)
//   i_push   in   write i_wdata at the tail
//   i_wdata  in   WIDTH-bit instruction to push
//   i_pop    in   remove the head entry (ignored when empty)
//   o_head   out  head entry
//   o_empty  out  no entries
//   o_full   out  DEPTH entries
//   o_count  out  current number of entries
//   o_drop   out  push rejected this cycle
// ----------------------------------------------------------------------------
module dbg_itr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count,
    output logic             o_drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    // A pop frees the head slot in the same edge, so a push into a full FIFO
    // can land there; DEPTH is a power of two so the pointers wrap by overflow.
    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);
    assign o_drop   = i_push & ~w_doPush;
    assign o_head   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_wdata;
                r_wrPtr        <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/core_dbg_unit.sv
// ----------------------------------------------------------------------------
// core_dbg_unit
// Debug register unit between the core debug APB slave and fetch. It holds a
// general register bank, a CTRL command register (halt / resume / clear
// overflow), a read-only STATUS snapshot, and an ITR push register that feeds
// a FIFO draining into fetch while the core is halted.
//
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   i_dbgOnRst    in   come out of reset HALTED instead of RUN
//   i_req         in   one-cycle access strobe
//   i_wrRd        in   1 = write, 0 = read
//   i_addr        in   register index
//   i_wdata       in   write data
//   o_rdata       out  registered read data
//   o_rdReady     out  read data valid, one cycle after a read request
//   i_coreQuiet   in   pipeline drained
//   o_halted      out  state is HALTED
//   o_itrValid    out  ITR instruction offered to fetch
//   o_itrInsn     out  FIFO head instruction
//   i_itrReady    in   fetch takes the offered instruction
// ----------------------------------------------------------------------------
module core_dbg_unit
    import core_dbg_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int ITR_DEPTH   = 4,
    parameter int CTRL_ADDR   = DBG_IDX_CTRL,
    parameter int STATUS_ADDR = DBG_IDX_STATUS,
    parameter int ITR_ADDR    = DBG_IDX_ITR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_dbgOnRst,
    input  logic                  i_req,
    input  logic                  i_wrRd,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rdReady,
    input  logic                  i_coreQuiet,
    output logic                  o_halted,
    output logic                  o_itrValid,
    output logic [DATA_WIDTH-1:0] o_itrInsn,
    input  logic                  i_itrReady
);

    localparam int CNT_W = $clog2(ITR_DEPTH + 1);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    DbgState               r_state;
    DbgState               w_nextState;
    logic [DATA_WIDTH-1:0] r_bank [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rdReady;
    logic                  r_overflow;

    logic                  w_wrReq;
    logic                  w_rdReq;
    logic                  w_inRange;
    logic                  w_isCtrl;
    logic                  w_isStatus;
    logic                  w_isItr;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_bankWr;
    logic                  w_ctrlWr;
    logic                  w_itrPush;
    logic                  w_haltReq;
    logic                  w_resumeReq;
    logic                  w_clrOvf;
    logic                  w_itrPop;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rdMux;

    logic [DATA_WIDTH-1:0] w_fifoHead;
    logic                  w_fifoEmpty;
    logic                  w_fifoFull;
    logic [CNT_W-1:0]      w_fifoCount;
    logic                  w_fifoDrop;

    // Address decode. The extra leading zero keeps the range compare correct
    // when NUM_REGS equals 2**ADDR_WIDTH.
    assign w_wrReq    = i_req & i_wrRd;
    assign w_rdReq    = i_req & ~i_wrRd;
    assign w_inRange  = ({1'b0, i_addr} < (ADDR_WIDTH + 1)'(NUM_REGS));
    assign w_isCtrl   = (i_addr == ADDR_WIDTH'(CTRL_ADDR));
    assign w_isStatus = (i_addr == ADDR_WIDTH'(STATUS_ADDR));
    assign w_isItr    = (i_addr == ADDR_WIDTH'(ITR_ADDR));
    assign w_idx      = i_addr[IDX_W-1:0];

    assign w_bankWr    = w_wrReq & w_inRange & ~w_isCtrl & ~w_isStatus & ~w_isItr;
    assign w_ctrlWr    = w_wrReq & w_inRange & w_isCtrl;
    assign w_itrPush   = w_wrReq & w_inRange & w_isItr;
    assign w_haltReq   = w_ctrlWr & i_wdata[DBG_CTRL_HALT];
    assign w_resumeReq = w_ctrlWr & i_wdata[DBG_CTRL_RESUME];
    assign w_clrOvf    = w_ctrlWr & i_wdata[DBG_CTRL_CLR_OVF];

    assign w_itrPop = o_itrValid & i_itrReady;

    dbg_itr_fifo #(
        .DEPTH (ITR_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_itrFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_itrPush),
        .i_wdata (i_wdata),
        .i_pop   (w_itrPop),
        .o_head  (w_fifoHead),
        .o_empty (w_fifoEmpty),
        .o_full  (w_fifoFull),
        .o_count (w_fifoCount),
        .o_drop  (w_fifoDrop)
    );

    // State register. dbg_on_rst is re-sampled on every edge while reset is
    // held, so the last value seen before release decides the start state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= i_dbgOnRst ? DBG_HALTED : DBG_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Halt is checked before resume so a combined request
    // halts. Resume out of HALTED is refused while instructions are queued.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            DBG_RUN: begin
                if (w_haltReq) begin
                    w_nextState = i_coreQuiet ? DBG_HALTED : DBG_HALTING;
                end
            end
            DBG_HALTING: begin
                if (i_coreQuiet) begin
                    w_nextState = DBG_HALTED;
                end
            end
            DBG_HALTED: begin
                if (w_resumeReq && !w_haltReq && w_fifoEmpty) begin
                    w_nextState = DBG_RUN;
                end
            end
            default: begin
                w_nextState = DBG_RUN;
            end
        endcase
    end

    // Outputs derived from the registered state; fetch only sees queued
    // instructions once the core is fully halted.
    always_comb begin
        o_halted   = (r_state == DBG_HALTED);
        o_itrValid = (r_state == DBG_HALTED) & ~w_fifoEmpty;
        o_itrInsn  = w_fifoHead;
    end

    // Sticky overflow flag. A drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_fifoDrop) begin
            r_overflow <= 1'b1;
        end else if (w_clrOvf) begin
            r_overflow <= 1'b0;
        end
    end

    // General-purpose register bank; CTRL, STATUS and ITR indices never land
    // here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_bankWr) begin
            r_bank[w_idx] <= i_wdata;
        end
    end

    // Live STATUS word, captured at the cycle of the read request.
    always_comb begin
        w_status = '0;
        w_status[DBG_STATUS_STATE_LSB +: DBG_STATUS_STATE_W] = r_state;
        w_status[DBG_STATUS_EMPTY]                           = w_fifoEmpty;
        w_status[DBG_STATUS_FULL]                            = w_fifoFull;
        w_status[DBG_STATUS_OVF]                             = r_overflow;
        w_status[DBG_STATUS_COUNT_LSB +: CNT_W]              = w_fifoCount;
    end

    // Read data selection; command and push registers read back as zero.
    always_comb begin
        w_rdMux = '0;
        if (w_inRange && !w_isCtrl && !w_isItr) begin
            if (w_isStatus) begin
                w_rdMux = w_status;
            end else begin
                w_rdMux = r_bank[w_idx];
            end
        end
    end

    // Registered read port. rdata holds its last value between reads while
    // rd_ready marks the single cycle that carries a fresh result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata   <= '0;
            r_rdReady <= 1'b0;
        end else begin
            r_rdReady <= w_rdReq;
            if (w_rdReq) begin
                r_rdata <= w_rdMux;
            end
        end
    end

    assign o_rdata   = r_rdata;
    assign o_rdReady = r_rdReady;

endmodule

// File: tb/tb_core_dbg_unit.sv
// ----------------------------------------------------------------------------
// tb_core_dbg_unit
// Self-checking bench for core_dbg_unit with NUM_REGS=16, ITR_DEPTH=4.
// Read results and ITR instructions are predicted into queues when the
// stimulus is driven and compared when the unit produces them.
// ----------------------------------------------------------------------------
module tb_core_dbg_unit;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 16;
    localparam int DEPTH = 4;

    localparam logic [AW-1:0] A_CTRL   = 5'd1;
    localparam logic [AW-1:0] A_STATUS = 5'd2;
    localparam logic [AW-1:0] A_ITR    = 5'd3;

    logic          clk;
    logic          rst_n;
    logic          i_dbgOnRst;
    logic          i_req;
    logic          i_wrRd;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic [DW-1:0] o_rdata;
    logic          o_rdReady;
    logic          i_coreQuiet;
    logic          o_halted;
    logic          o_itrValid;
    logic [DW-1:0] o_itrInsn;
    logic          i_itrReady;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] expRdata;
    } VecT;

    VecT           vecs [15];
    logic [DW-1:0] rdExpQ [$];
    logic [DW-1:0] itrExpQ [$];
    logic [DW-1:0] monExp;
    int            checks = 0;
    int            errors = 0;

    core_dbg_unit #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NR),
        .ITR_DEPTH   (DEPTH),
        .CTRL_ADDR   (1),
        .STATUS_ADDR (2),
        .ITR_ADDR    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_dbgOnRst  (i_dbgOnRst),
        .i_req       (i_req),
        .i_wrRd      (i_wrRd),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_rdReady   (o_rdReady),
        .i_coreQuiet (i_coreQuiet),
        .o_halted    (o_halted),
        .o_itrValid  (o_itrValid),
        .o_itrInsn   (o_itrInsn),
        .i_itrReady  (i_itrReady)
    );

    // Free-running clock, first rising edge at 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One register access: driven on a falling edge, held across one rising
    // edge. A read pushes its predicted result onto the scoreboard.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] expRdata);
        @(negedge clk);
        if (!wr) begin
            rdExpQ.push_back(expRdata);
        end
        i_req   = 1'b1;
        i_wrRd  = wr;
        i_addr  = addr;
        i_wdata = wdata;
        @(negedge clk);
        i_req   = 1'b0;
        i_wrRd  = 1'b0;
    endtask

    task automatic writeReg(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        applyStimulus(1'b1, addr, data, '0);
    endtask

    task automatic readReg(input logic [AW-1:0] addr, input logic [DW-1:0] expData);
        applyStimulus(1'b0, addr, '0, expData);
    endtask

    task automatic pushItr(input logic [DW-1:0] data, input logic accepted);
        if (accepted) begin
            itrExpQ.push_back(data);
        end
        applyStimulus(1'b1, A_ITR, data, '0);
    endtask

    task automatic waitItrDrain(input int maxCycles);
        int n;
        n = 0;
        while (itrExpQ.size() != 0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (itrExpQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL itr_drain: %0d instructions still expected, 0 required",
                     itrExpQ.size());
            itrExpQ.delete();
        end
    endtask

    // Monitor: samples one time unit before each rising edge, where both the
    // registered outputs and the handshake inputs are settled.
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            if (o_rdReady) begin
                checks++;
                if (rdExpQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rd_ready_unexpected: rd_ready=1 rdata=0x%08h, required rd_ready=0",
                             o_rdata);
                end else begin
                    monExp = rdExpQ.pop_front();
                    if (o_rdata !== monExp) begin
                        errors++;
                        $display("[TB] FAIL rdata: got 0x%08h, expected 0x%08h", o_rdata, monExp);
                    end
                end
            end
            if (o_itrValid && i_itrReady) begin
                checks++;
                if (itrExpQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL itr_unexpected: insn 0x%08h offered, none required", o_itrInsn);
                end else begin
                    monExp = itrExpQ.pop_front();
                    if (o_itrInsn !== monExp) begin
                        errors++;
                        $display("[TB] FAIL itr_insn: got 0x%08h, expected 0x%08h", o_itrInsn, monExp);
                    end
                end
            end
        end
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running at 200000, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 5'd5,  32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 5'd15, 32'hA5A5_5A5A, 32'h0};
        vecs[3]  = '{1'b0, 5'd15, 32'h0,         32'hA5A5_5A5A};
        vecs[4]  = '{1'b0, 5'd31, 32'h0,         32'h0};
        vecs[5]  = '{1'b0, 5'd16, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 5'd16, 32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         32'h0};
        vecs[8]  = '{1'b1, 5'd2,  32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{1'b0, 5'd2,  32'h0,         32'h0000_0006};
        vecs[10] = '{1'b0, 5'd1,  32'h0,         32'h0};
        vecs[11] = '{1'b0, 5'd3,  32'h0,         32'h0};
        vecs[12] = '{1'b1, 5'd4,  32'h1234_5678, 32'h0};
        vecs[13] = '{1'b0, 5'd4,  32'h0,         32'h1234_5678};
        vecs[14] = '{1'b0, 5'd5,  32'h0,         32'hDEAD_BEEF};

        rst_n       = 1'b0;
        i_dbgOnRst  = 1'b1;
        i_req       = 1'b0;
        i_wrRd      = 1'b0;
        i_addr      = '0;
        i_wdata     = '0;
        i_coreQuiet = 1'b0;
        i_itrReady  = 1'b0;

        // Reset into HALTED.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_halted",   32'(o_halted),   32'd1);
        checkOutput("reset_rd_ready", 32'(o_rdReady),  32'd0);
        checkOutput("reset_itr_valid",32'(o_itrValid), 32'd0);
        readReg(A_STATUS, 32'h0000_0006);

        // Register bank, out-of-range, aliasing and read-only indices.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].expRdata);
        end
        checkOutput("status_write_halted", 32'(o_halted), 32'd1);

        // Fill, overflow and drain the ITR FIFO while halted.
        pushItr(32'h11, 1'b1);
        pushItr(32'h22, 1'b1);
        pushItr(32'h33, 1'b1);
        pushItr(32'h44, 1'b1);
        readReg(A_STATUS, 32'h0000_040A);
        pushItr(32'h55, 1'b0);
        readReg(A_STATUS, 32'h0000_041A);
        checkOutput("itr_valid_full", 32'(o_itrValid), 32'd1);
        checkOutput("itr_head_full",  o_itrInsn,       32'h11);
        i_itrReady = 1'b1;
        waitItrDrain(20);
        checkOutput("itr_valid_drained", 32'(o_itrValid), 32'd0);
        i_itrReady = 1'b0;
        readReg(A_STATUS, 32'h0000_0016);

        // Push and pop together on a full FIFO, then clear overflow.
        pushItr(32'h21, 1'b1);
        pushItr(32'h32, 1'b1);
        pushItr(32'h43, 1'b1);
        pushItr(32'h54, 1'b1);
        @(negedge clk);
        itrExpQ.push_back(32'h66);
        i_req      = 1'b1;
        i_wrRd     = 1'b1;
        i_addr     = A_ITR;
        i_wdata    = 32'h66;
        i_itrReady = 1'b1;
        @(negedge clk);
        i_req      = 1'b0;
        i_wrRd     = 1'b0;
        i_itrReady = 1'b0;
        readReg(A_STATUS, 32'h0000_041A);
        writeReg(A_CTRL, 32'h4);
        readReg(A_STATUS, 32'h0000_040A);
        i_itrReady = 1'b1;
        waitItrDrain(20);
        i_itrReady = 1'b0;
        readReg(A_STATUS, 32'h0000_0006);

        // Run control: RUN -> HALTING -> HALTED, refused and accepted resumes.
        writeReg(A_CTRL, 32'h2);
        checkOutput("resume_to_run", 32'(o_halted), 32'd0);
        readReg(A_STATUS, 32'h0000_0004);
        i_coreQuiet = 1'b0;
        writeReg(A_CTRL, 32'h1);
        checkOutput("halting_not_halted", 32'(o_halted), 32'd0);
        readReg(A_STATUS, 32'h0000_0005);
        writeReg(A_CTRL, 32'h2);
        readReg(A_STATUS, 32'h0000_0005);
        @(negedge clk);
        i_coreQuiet = 1'b1;
        @(negedge clk);
        checkOutput("quiet_to_halted", 32'(o_halted), 32'd1);
        i_coreQuiet = 1'b0;
        pushItr(32'h13, 1'b1);
        writeReg(A_CTRL, 32'h2);
        readReg(A_STATUS, 32'h0000_0102);
        i_itrReady = 1'b1;
        waitItrDrain(10);
        i_itrReady = 1'b0;
        writeReg(A_CTRL, 32'h2);
        checkOutput("resume_after_pop", 32'(o_halted), 32'd0);
        readReg(A_STATUS, 32'h0000_0004);
        i_coreQuiet = 1'b1;
        writeReg(A_CTRL, 32'h3);
        checkOutput("halt_wins_direct", 32'(o_halted), 32'd1);
        readReg(A_STATUS, 32'h0000_0006);
        writeReg(A_CTRL, 32'h2);
        readReg(A_STATUS, 32'h0000_0004);

        // Pushes queue in RUN; reset in the middle of a handshake.
        pushItr(32'h71, 1'b1);
        pushItr(32'h72, 1'b1);
        checkOutput("run_itr_valid", 32'(o_itrValid), 32'd0);
        readReg(A_STATUS, 32'h0000_0200);
        writeReg(A_CTRL, 32'h1);
        checkOutput("halt_itr_valid", 32'(o_itrValid), 32'd1);
        checkOutput("halt_itr_head",  o_itrInsn,       32'h71);
        i_coreQuiet = 1'b0;
        @(negedge clk);
        i_itrReady = 1'b1;
        #2;
        i_dbgOnRst = 1'b0;
        rst_n      = 1'b0;
        itrExpQ.delete();
        #1;
        checkOutput("rst_itr_valid", 32'(o_itrValid), 32'd0);
        checkOutput("rst_halted",    32'(o_halted),   32'd0);
        @(negedge clk);
        i_itrReady = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        readReg(A_STATUS, 32'h0000_0004);

        // Let the final response arrive, then confirm nothing is outstanding.
        repeat (3) @(negedge clk);
        checks++;
        if (rdExpQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL rd_missing: %0d reads without rd_ready, 0 required", rdExpQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
